// File: rtl/bf_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bf_bus_ctrl
// Purpose  : Stalls the BF core across memory/IO transactions and shares the
//            memory port round-robin with a host loader/debug port.
// Revision : 1.0 - initial release
// ============================================================================
module bf_bus_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_val_out,
    input  logic [2:0]            core_bus_op,
    output logic [DATA_WIDTH-1:0] core_val_in,
    output logic                  core_enable,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH:0]   host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_ack,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  io_out_valid,
    output logic [DATA_WIDTH-1:0] io_out_data,
    input  logic                  io_out_ready,
    input  logic                  io_in_valid,
    input  logic [DATA_WIDTH-1:0] io_in_data,
    output logic                  io_in_ready,
    output logic                  bus_err
);

    localparam logic [2:0] c_OP_NONE       = 3'd0;
    localparam logic [2:0] c_OP_READ_PROG  = 3'd1;
    localparam logic [2:0] c_OP_READ_DATA  = 3'd2;
    localparam logic [2:0] c_OP_WRITE_DATA = 3'd3;
    localparam logic [2:0] c_OP_READ_IO    = 3'd4;
    localparam logic [2:0] c_OP_WRITE_IO   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CORE_MEM    = 3'd1,
        ST_CORE_IO_OUT = 3'd2,
        ST_CORE_IO_IN  = 3'd3,
        ST_CORE_DONE   = 3'd4,
        ST_HOST_MEM    = 3'd5,
        ST_HOST_DONE   = 3'd6
    } state_t;

    state_t                r_state;
    logic                  r_last_host;
    logic [DATA_WIDTH-1:0] r_core_val_in;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic                  r_host_ack;
    logic                  r_mem_re;
    logic                  r_mem_we;
    logic [ADDR_WIDTH:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_io_out_valid;
    logic [DATA_WIDTH-1:0] r_io_out_data;
    logic                  r_io_in_ready;
    logic                  r_bus_err;

    logic w_op_none;
    logic w_op_mem;
    logic w_host_win;
    logic w_core_enable;

    assign w_op_none = (core_bus_op == c_OP_NONE);
    assign w_op_mem  = (core_bus_op == c_OP_READ_PROG) ||
                       (core_bus_op == c_OP_READ_DATA) ||
                       (core_bus_op == c_OP_WRITE_DATA);

    // Host only contends with core memory ops; core IO/error ops never wait.
    assign w_host_win = host_req && (w_op_none || (w_op_mem && !r_last_host));

    always_comb begin
        w_core_enable = 1'b0;
        case (r_state)
            ST_IDLE:      w_core_enable = run && w_op_none;
            ST_CORE_DONE: w_core_enable = run;
            ST_HOST_MEM,
            ST_HOST_DONE: w_core_enable = run && w_op_none;
            default:      w_core_enable = 1'b0;
        endcase
    end

    // Reset forces the enable low immediately, not just at the next edge.
    assign core_enable = w_core_enable && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_last_host    <= 1'b0;
            r_core_val_in  <= '0;
            r_host_rdata   <= '0;
            r_host_ack     <= 1'b0;
            r_mem_re       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_io_out_valid <= 1'b0;
            r_io_out_data  <= '0;
            r_io_in_ready  <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_host_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_host_win) begin
                        r_state     <= ST_HOST_MEM;
                        r_last_host <= 1'b1;
                        r_mem_addr  <= host_addr;
                        r_mem_wdata <= host_wdata;
                        r_mem_we    <= host_we;
                        r_mem_re    <= !host_we;
                    end else if (!w_op_none) begin
                        r_last_host <= 1'b0;
                        if (w_op_mem) begin
                            r_state     <= ST_CORE_MEM;
                            r_mem_addr  <= {core_bus_op != c_OP_READ_PROG, core_addr};
                            r_mem_wdata <= core_val_out;
                            r_mem_we    <= (core_bus_op == c_OP_WRITE_DATA);
                            r_mem_re    <= (core_bus_op != c_OP_WRITE_DATA);
                        end else if (core_bus_op == c_OP_WRITE_IO) begin
                            r_state        <= ST_CORE_IO_OUT;
                            r_io_out_valid <= 1'b1;
                            r_io_out_data  <= core_val_out;
                        end else if (core_bus_op == c_OP_READ_IO) begin
                            r_state       <= ST_CORE_IO_IN;
                            r_io_in_ready <= 1'b1;
                        end else begin
                            r_state   <= ST_CORE_DONE;
                            r_bus_err <= 1'b1;
                        end
                    end
                end
                ST_CORE_MEM: begin
                    if (mem_ready) begin
                        if (r_mem_re) begin
                            r_core_val_in <= mem_rdata;
                        end
                        r_mem_re <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_state  <= ST_CORE_DONE;
                    end
                end
                ST_CORE_IO_OUT: begin
                    if (io_out_ready) begin
                        r_io_out_valid <= 1'b0;
                        r_state        <= ST_CORE_DONE;
                    end
                end
                ST_CORE_IO_IN: begin
                    if (io_in_valid) begin
                        r_core_val_in <= io_in_data;
                        r_io_in_ready <= 1'b0;
                        r_state       <= ST_CORE_DONE;
                    end
                end
                ST_CORE_DONE: begin
                    // Holding here until run keeps the still-presented op from re-triggering.
                    if (run) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOST_MEM: begin
                    if (mem_ready) begin
                        if (r_mem_re) begin
                            r_host_rdata <= mem_rdata;
                        end
                        r_mem_re   <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_host_ack <= 1'b1;
                        r_state    <= ST_HOST_DONE;
                    end
                end
                ST_HOST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_val_in  = r_core_val_in;
    assign host_rdata   = r_host_rdata;
    assign host_ack     = r_host_ack;
    assign mem_re       = r_mem_re;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign io_out_valid = r_io_out_valid;
    assign io_out_data  = r_io_out_data;
    assign io_in_ready  = r_io_in_ready;
    assign bus_err      = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_bf_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_bus_ctrl
// Purpose  : Directed self-checking bench for bf_bus_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bf_bus_ctrl;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] core_addr;
    logic [7:0]  core_val_out;
    logic [2:0]  core_bus_op;
    logic [7:0]  core_val_in;
    logic        core_enable;
    logic        host_req;
    logic        host_we;
    logic [16:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic        mem_re;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        io_out_valid;
    logic [7:0]  io_out_data;
    logic        io_out_ready;
    logic        io_in_valid;
    logic [7:0]  io_in_data;
    logic        io_in_ready;
    logic        bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    bf_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .core_addr    (core_addr),
        .core_val_out (core_val_out),
        .core_bus_op  (core_bus_op),
        .core_val_in  (core_val_in),
        .core_enable  (core_enable),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .host_ack     (host_ack),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .io_out_valid (io_out_valid),
        .io_out_data  (io_out_data),
        .io_out_ready (io_out_ready),
        .io_in_valid  (io_in_valid),
        .io_in_data   (io_in_data),
        .io_in_ready  (io_in_ready),
        .bus_err      (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 units after the edge.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; run = 1'b1;
        core_addr = '0; core_val_out = '0; core_bus_op = 3'd0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        io_out_ready = 1'b0; io_in_valid = 1'b0; io_in_data = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_core_enable", {31'd0, core_enable}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_core_val_in", {24'd0, core_val_in}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_io_out_valid", {31'd0, io_out_valid}, 32'd0);
        reset = 1'b0;
        cyc();
        #1 chk("idle_enable", {31'd0, core_enable}, 32'd1);

        // ReadData 0x0010, memory ready after 3 wait cycles
        core_bus_op = 3'd2; core_addr = 16'h0010; mem_rdata = 8'h41; mem_ready = 1'b0;
        #1 chk("rd_stall_c0", {31'd0, core_enable}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) mem_ready = 1'b1;
            #1;
            chk("rd_mem_re", {31'd0, mem_re}, 32'd1);
            chk("rd_mem_addr", {15'd0, mem_addr}, 32'h10010);
            chk("rd_enable_low", {31'd0, core_enable}, 32'd0);
        end
        cyc();
        chk("rd_done_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rd_done_enable", {31'd0, core_enable}, 32'd1);
        chk("rd_val_in", {24'd0, core_val_in}, 32'h41);
        core_bus_op = 3'd0; mem_ready = 1'b0; mem_rdata = 8'h00;
        cyc(); cyc();
        chk("rd_val_held", {24'd0, core_val_in}, 32'h41);

        // Host write 0x2B to 0x00005
        host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00005; host_wdata = 8'h2B; mem_ready = 1'b1;
        cyc();
        #1;
        chk("hw_mem_we", {31'd0, mem_we}, 32'd1);
        chk("hw_mem_re", {31'd0, mem_re}, 32'd0);
        chk("hw_mem_addr", {15'd0, mem_addr}, 32'h00005);
        chk("hw_mem_wdata", {24'd0, mem_wdata}, 32'h2B);
        chk("hw_core_free", {31'd0, core_enable}, 32'd1);
        chk("hw_no_ack_yet", {31'd0, host_ack}, 32'd0);
        cyc();
        chk("hw_ack", {31'd0, host_ack}, 32'd1);
        chk("hw_we_clear", {31'd0, mem_we}, 32'd0);
        host_req = 1'b0;
        cyc();
        chk("hw_ack_pulse", {31'd0, host_ack}, 32'd0);

        // Core ReadProg at 0x0005 returns the host-written byte
        core_bus_op = 3'd1; core_addr = 16'h0005; mem_rdata = 8'h2B;
        cyc();
        chk("rp_mem_re", {31'd0, mem_re}, 32'd1);
        chk("rp_mem_addr", {15'd0, mem_addr}, 32'h00005);
        cyc();
        chk("rp_val_in", {24'd0, core_val_in}, 32'h2B);
        chk("rp_enable", {31'd0, core_enable}, 32'd1);
        core_bus_op = 3'd0;
        cyc();

        // Host read of the data region
        host_req = 1'b1; host_we = 1'b0; host_addr = 17'h10020; mem_rdata = 8'h77;
        cyc();
        chk("hr_mem_re", {31'd0, mem_re}, 32'd1);
        chk("hr_mem_addr", {15'd0, mem_addr}, 32'h10020);
        cyc();
        chk("hr_ack", {31'd0, host_ack}, 32'd1);
        chk("hr_rdata", {24'd0, host_rdata}, 32'h77);
        chk("hr_core_val_held", {24'd0, core_val_in}, 32'h2B);
        host_req = 1'b0;
        cyc();

        // ReadIo with run low: completion enable held until run returns
        core_bus_op = 3'd4; io_in_valid = 1'b1; io_in_data = 8'h5A; run = 1'b0;
        cyc();
        chk("ri_in_ready", {31'd0, io_in_ready}, 32'd1);
        cyc();
        chk("ri_val_in", {24'd0, core_val_in}, 32'h5A);
        chk("ri_in_ready_clr", {31'd0, io_in_ready}, 32'd0);
        chk("ri_enable_held", {31'd0, core_enable}, 32'd0);
        io_in_valid = 1'b0;
        cyc();
        chk("ri_enable_still", {31'd0, core_enable}, 32'd0);
        run = 1'b1;
        #1 chk("ri_enable_run", {31'd0, core_enable}, 32'd1);
        core_bus_op = 3'd0;
        cyc();

        // WriteIo 0x48 with sink not ready for 5 cycles
        core_bus_op = 3'd5; core_val_out = 8'h48; io_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 5) io_out_ready = 1'b1;
            #1;
            chk("wo_valid", {31'd0, io_out_valid}, 32'd1);
            chk("wo_data", {24'd0, io_out_data}, 32'h48);
            chk("wo_enable_low", {31'd0, core_enable}, 32'd0);
        end
        cyc();
        chk("wo_valid_clr", {31'd0, io_out_valid}, 32'd0);
        chk("wo_enable_pulse", {31'd0, core_enable}, 32'd1);
        core_bus_op = 3'd0; io_out_ready = 1'b0;
        cyc();

        // Illegal op 7
        core_bus_op = 3'd7;
        #1 chk("err_stall", {31'd0, core_enable}, 32'd0);
        cyc();
        chk("err_flag", {31'd0, bus_err}, 32'd1);
        chk("err_strobes", {28'd0, mem_re, mem_we, io_out_valid, io_in_ready}, 32'd0);
        chk("err_enable", {31'd0, core_enable}, 32'd1);
        core_bus_op = 3'd0;
        cyc(); cyc();
        chk("err_sticky", {31'd0, bus_err}, 32'd1);

        // Contest 1: host wins; contest 2 (host re-requests): core wins
        core_bus_op = 3'd3; core_addr = 16'h0030; core_val_out = 8'h99;
        host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00100; host_wdata = 8'h11; mem_ready = 1'b1;
        cyc();
        chk("arb1_host_addr", {15'd0, mem_addr}, 32'h00100);
        chk("arb1_host_data", {24'd0, mem_wdata}, 32'h11);
        chk("arb1_core_stalled", {31'd0, core_enable}, 32'd0);
        cyc();
        chk("arb1_ack", {31'd0, host_ack}, 32'd1);
        host_req = 1'b0;
        cyc();
        host_req = 1'b1; host_addr = 17'h00101; host_wdata = 8'h22;
        cyc();
        chk("arb2_core_we", {31'd0, mem_we}, 32'd1);
        chk("arb2_core_addr", {15'd0, mem_addr}, 32'h10030);
        chk("arb2_core_data", {24'd0, mem_wdata}, 32'h99);
        cyc();
        chk("arb2_core_done", {31'd0, core_enable}, 32'd1);
        core_bus_op = 3'd0;
        cyc();
        cyc();
        chk("arb2_host_addr", {15'd0, mem_addr}, 32'h00101);
        chk("arb2_host_data", {24'd0, mem_wdata}, 32'h22);
        cyc();
        chk("arb2_host_ack", {31'd0, host_ack}, 32'd1);
        host_req = 1'b0;
        cyc();

        // Asynchronous reset during CORE_MEM
        core_bus_op = 3'd2; core_addr = 16'h0040; mem_ready = 1'b0;
        cyc();
        chk("ar_mem_re", {31'd0, mem_re}, 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_mem_re_clr", {31'd0, mem_re}, 32'd0);
        chk("ar_val_in_clr", {24'd0, core_val_in}, 32'd0);
        chk("ar_enable_clr", {31'd0, core_enable}, 32'd0);
        chk("ar_bus_err_clr", {31'd0, bus_err}, 32'd0);
        core_bus_op = 3'd0;
        cyc();
        reset = 1'b0;
        cyc();
        #1;
        chk("ar_idle_enable", {31'd0, core_enable}, 32'd1);
        chk("ar_idle_mem_re", {31'd0, mem_re}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
